// File: rtl/stdp_kernel_lut.sv
// STDP kernel lookup: request FIFO feeding a lookup stage (L) and an output stage (O),
// with runtime-writable potentiation/depression tables.
module stdp_kernel_lut #(
    parameter int DT_W       = 8,
    parameter int OUT_W      = 24,
    parameter int DEPTH      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic                     cfg_sel,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [OUT_W-1:0]         cfg_data,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_sign,
    input  logic [DT_W-1:0]          req_mag,
    input  logic [TAG_W-1:0]         req_tag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [OUT_W-1:0]         rsp_val,
    output logic                     rsp_sign,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     rsp_clip,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + DT_W + TAG_W;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // a producer holding valid keeps its payload stable until that edge.

    logic [OUT_W-1:0] plus_q  [DEPTH];
    logic [OUT_W-1:0] plus_d  [DEPTH];
    logic [OUT_W-1:0] minus_q [DEPTH];
    logic [OUT_W-1:0] minus_d [DEPTH];

    logic [EW-1:0]    fifo_q [FIFO_DEPTH];
    logic [EW-1:0]    fifo_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             l_valid_q, l_valid_d;
    logic             l_sign_q, l_sign_d;
    logic [TAG_W-1:0] l_tag_q, l_tag_d;
    logic [OUT_W-1:0] l_val_q, l_val_d;
    logic             l_clip_q, l_clip_d;

    logic             o_valid_q, o_valid_d;
    logic             o_sign_q, o_sign_d;
    logic [TAG_W-1:0] o_tag_q, o_tag_d;
    logic [OUT_W-1:0] o_val_q, o_val_d;
    logic             o_clip_q, o_clip_d;

    logic             fifo_full, fifo_empty, push, pop;
    logic             o_free, l_free;
    logic [EW-1:0]    head;
    logic             head_sign;
    logic [DT_W-1:0]  head_mag;
    logic [TAG_W-1:0] head_tag;
    logic [AW-1:0]    head_idx;
    logic             head_clip;
    logic [OUT_W-1:0] head_val;

    // Table writes land at the edge; a capture on that same edge still reads the old entry.
    always_comb begin
        plus_d  = plus_q;
        minus_d = minus_q;
        if (cfg_we) begin
            if (cfg_sel) plus_d[cfg_addr]  = cfg_data;
            else         minus_d[cfg_addr] = cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                plus_q[i]  <= '0;
                minus_q[i] <= '0;
            end
        end else begin
            plus_q  <= plus_d;
            minus_q <= minus_d;
        end
    end

    always_comb begin
        o_free     = !o_valid_q || rsp_ready;
        l_free     = !l_valid_q || o_free;
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        push       = req_valid && !fifo_full;
        pop        = l_free && !fifo_empty;

        head      = fifo_q[rd_ptr_q];
        head_sign = head[EW-1];
        head_mag  = head[TAG_W +: DT_W];
        head_tag  = head[TAG_W-1:0];
        head_idx  = head_mag[AW-1:0];
        head_clip = ((head_mag >> AW) != '0);
        head_val  = '0;
        if (!head_clip) head_val = head_sign ? plus_q[head_idx] : minus_q[head_idx];
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {req_sign, req_mag, req_tag};
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // L refills from the FIFO whenever it empties or hands off to O; otherwise it holds.
    always_comb begin
        l_valid_d = l_valid_q;
        l_sign_d  = l_sign_q;
        l_tag_d   = l_tag_q;
        l_val_d   = l_val_q;
        l_clip_d  = l_clip_q;
        if (l_free) l_valid_d = pop;
        if (pop) begin
            l_sign_d = head_sign;
            l_tag_d  = head_tag;
            l_val_d  = head_val;
            l_clip_d = head_clip;
        end
    end

    always_comb begin
        o_valid_d = o_valid_q;
        o_sign_d  = o_sign_q;
        o_tag_d   = o_tag_q;
        o_val_d   = o_val_q;
        o_clip_d  = o_clip_q;
        if (o_free) begin
            o_valid_d = l_valid_q;
            if (l_valid_q) begin
                o_sign_d = l_sign_q;
                o_tag_d  = l_tag_q;
                o_val_d  = l_val_q;
                o_clip_d = l_clip_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            l_valid_q <= 1'b0;
            l_sign_q  <= 1'b0;
            l_tag_q   <= '0;
            l_val_q   <= '0;
            l_clip_q  <= 1'b0;
            o_valid_q <= 1'b0;
            o_sign_q  <= 1'b0;
            o_tag_q   <= '0;
            o_val_q   <= '0;
            o_clip_q  <= 1'b0;
        end else begin
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            l_valid_q <= l_valid_d;
            l_sign_q  <= l_sign_d;
            l_tag_q   <= l_tag_d;
            l_val_q   <= l_val_d;
            l_clip_q  <= l_clip_d;
            o_valid_q <= o_valid_d;
            o_sign_q  <= o_sign_d;
            o_tag_q   <= o_tag_d;
            o_val_q   <= o_val_d;
            o_clip_q  <= o_clip_d;
        end
    end

    assign req_ready = !fifo_full;
    assign rsp_valid = o_valid_q;
    assign rsp_val   = o_val_q;
    assign rsp_sign  = o_sign_q;
    assign rsp_tag   = o_tag_q;
    assign rsp_clip  = o_clip_q;
    assign busy      = !fifo_empty || l_valid_q || o_valid_q;

endmodule

// File: tb/tb_stdp_kernel_lut.sv
// Bench for stdp_kernel_lut: directed scenarios plus randomized traffic against a
// table/queue reference model, checked every cycle by one monitor process.
module tb_stdp_kernel_lut;

    localparam int DT_W  = 8;
    localparam int OUT_W = 24;
    localparam int DEPTH = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int XW    = 2 + TAG_W + OUT_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_we = 1'b0;
    logic             cfg_sel = 1'b0;
    logic [4:0]       cfg_addr = '0;
    logic [OUT_W-1:0] cfg_data = '0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_sign = 1'b0;
    logic [DT_W-1:0]  req_mag = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [OUT_W-1:0] rsp_val;
    logic             rsp_sign;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_clip;
    logic             busy;

    stdp_kernel_lut #(
        .DT_W(DT_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_sign(req_sign),
        .req_mag(req_mag), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_val(rsp_val),
        .rsp_sign(rsp_sign), .rsp_tag(rsp_tag), .rsp_clip(rsp_clip), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_rsp = 0;
    logic [XW-1:0]    exp_q [$];
    logic [OUT_W-1:0] m_plus  [DEPTH];
    logic [OUT_W-1:0] m_minus [DEPTH];
    logic             prev_stall = 1'b0;
    logic [XW-1:0]    prev_out = '0;
    logic [XW-1:0]    mon_cur;
    logic [XW-1:0]    mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, want, $time);
        end
    endtask

    // Reference: out-of-range magnitude clips to zero, otherwise the entry of the signed table.
    function automatic logic [XW-1:0] model(input logic s, input logic [DT_W-1:0] mag,
                                            input logic [TAG_W-1:0] tag);
        logic             clip;
        logic [OUT_W-1:0] v;
        int               m;
        m    = int'(mag);
        clip = (m >= DEPTH);
        v    = '0;
        if (!clip) v = s ? m_plus[m] : m_minus[m];
        return {clip, s, tag, v};
    endfunction

    // Monitor: samples at negedge what the next rising edge will transfer.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) begin
                m_plus[i]  = '0;
                m_minus[i] = '0;
            end
            prev_stall = 1'b0;
        end else begin
            mon_cur = {rsp_clip, rsp_sign, rsp_tag, rsp_val};
            chk("busy", {31'b0, busy}, {31'b0, exp_q.size() != 0});
            if (prev_stall) chk("stall_hold", {1'b0, rsp_valid, mon_cur}, {2'b01, prev_out});
            if (rsp_valid) chk("rsp_pending", {31'b0, exp_q.size() != 0}, 32'd1);
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                chk("rsp_data", {2'b0, mon_cur}, {2'b0, mon_exp});
                n_rsp++;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_out   = mon_cur;
            if (req_valid && req_ready) exp_q.push_back(model(req_sign, req_mag, req_tag));
            if (cfg_we) begin
                if (cfg_sel) m_plus[cfg_addr]  = cfg_data;
                else         m_minus[cfg_addr] = cfg_data;
            end
        end
    end

    task automatic cfg_write(input logic sel, input logic [4:0] addr, input logic [OUT_W-1:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send_req(input logic s, input logic [DT_W-1:0] mag, input logic [TAG_W-1:0] tag);
        bit acc = 0;
        req_valid = 1'b1;
        req_sign  = s;
        req_mag   = mag;
        req_tag   = tag;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("req_accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic wait_rsp(output logic [XW-1:0] r);
        bit got = 0;
        r = '0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                got = 1;
                r   = {rsp_clip, rsp_sign, rsp_tag, rsp_val};
            end
        end
        chk("rsp_arrive", {31'b0, got}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic lookup(input logic s, input logic [DT_W-1:0] mag, input logic [TAG_W-1:0] tag,
                          output logic [XW-1:0] r);
        send_req(s, mag, tag);
        wait_rsp(r);
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
            @(posedge clk); #1;
        end
        chk("drain_idle", {31'b0, idle}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XW-1:0] r;
        int acc_n;
        int n0;
        bit acc;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_fields", {2'b0, rsp_clip, rsp_sign, rsp_tag, rsp_val}, 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        lookup(1'b1, 8'd5, 4'd2, r);
        chk("t1_val_zero", {8'b0, r[23:0]}, 32'd0);

        // Programmed entries and T+2 latency
        cfg_write(1'b0, 5'd3, 24'h00010D);
        cfg_write(1'b1, 5'd3, 24'h0022F2);
        send_req(1'b0, 8'd3, 4'd7);
        @(negedge clk);
        chk("lat_T0", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("lat_T1", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("lat_T2", {31'b0, rsp_valid}, 32'd1);
        chk("t2_minus_val", {8'b0, rsp_val}, 32'h00010D);
        chk("t2_tag", {28'b0, rsp_tag}, 32'd7);
        chk("t2_sign", {31'b0, rsp_sign}, 32'd0);
        @(posedge clk); #1;
        lookup(1'b1, 8'd3, 4'd8, r);
        chk("t2_plus_val", {8'b0, r[23:0]}, 32'h0022F2);
        chk("t2_plus_tag", {28'b0, r[27:24]}, 32'd8);
        chk("t2_plus_sign", {31'b0, r[28]}, 32'd1);

        // Clip boundary
        cfg_write(1'b1, 5'd31, 24'hABCDE1);
        lookup(1'b1, 8'd40, 4'd1, r);
        chk("clip40_val", {8'b0, r[23:0]}, 32'd0);
        chk("clip40_flag", {31'b0, r[29]}, 32'd1);
        lookup(1'b1, 8'd31, 4'd2, r);
        chk("mag31_val", {8'b0, r[23:0]}, 32'hABCDE1);
        chk("mag31_flag", {31'b0, r[29]}, 32'd0);
        lookup(1'b0, 8'd32, 4'd3, r);
        chk("clip32_flag", {31'b0, r[29]}, 32'd1);

        // Backpressure: capacity is FIFO plus both stages
        rsp_ready = 1'b0;
        acc_n     = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req_tag  = 4'(acc_n);
            req_mag  = 8'(acc_n);
            req_sign = acc_n[0];
            @(negedge clk);
            if (req_ready) acc_n++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("bp_accepted", acc_n, 32'd6);
        chk("bp_req_ready_low", {31'b0, req_ready}, 32'd0);
        n0 = n_rsp;
        rsp_ready = 1'b1;
        wait_idle();
        chk("bp_delivered", n_rsp - n0, 32'd6);

        // Table write colliding with the lookup capture
        cfg_write(1'b0, 5'd5, 24'h0A0A0A);
        send_req(1'b0, 8'd5, 4'd9);
        cfg_write(1'b0, 5'd5, 24'h0B0B0B);
        wait_rsp(r);
        chk("collide_old", {8'b0, r[23:0]}, 32'h0A0A0A);
        lookup(1'b0, 8'd5, 4'd10, r);
        chk("collide_new", {8'b0, r[23:0]}, 32'h0B0B0B);

        // Randomized traffic with table reprogramming between bursts
        for (int a = 0; a < DEPTH; a++) begin
            cfg_write(1'b1, 5'(a), 24'($urandom()));
            cfg_write(1'b0, 5'(a), 24'($urandom()));
        end
        for (int b = 0; b < 8; b++) begin
            rsp_ready = 1'b1;
            req_valid = 1'b0;
            wait_idle();
            for (int k = 0; k < 6; k++)
                cfg_write(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 24'($urandom()));
            acc = 1;
            for (int c = 0; c < 60; c++) begin
                if (!req_valid || acc) begin
                    req_valid = ($urandom_range(0, 9) < 6);
                    req_sign  = 1'($urandom_range(0, 1));
                    req_mag   = 8'($urandom_range(0, 47));
                    req_tag   = 4'($urandom_range(0, 15));
                end
                rsp_ready = ($urandom_range(0, 9) < (b % 2 == 0 ? 7 : 3));
                @(negedge clk);
                acc = req_valid && req_ready;
                @(posedge clk); #1;
            end
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        wait_idle();
        chk("rand_queue_empty", exp_q.size(), 32'd0);

        // Asynchronous reset with requests in flight
        rsp_ready = 1'b0;
        send_req(1'b1, 8'd3, 4'd1);
        send_req(1'b0, 8'd3, 4'd2);
        send_req(1'b1, 8'd5, 4'd3);
        #1 rst = 1'b0;
        #1;
        chk("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_req_ready", {31'b0, req_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("arst_no_stale", {31'b0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        lookup(1'b1, 8'd3, 4'd4, r);
        chk("arst_plus_cleared", {8'b0, r[23:0]}, 32'd0);
        lookup(1'b0, 8'd5, 4'd5, r);
        chk("arst_minus_cleared", {8'b0, r[23:0]}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
